// File: rtl/instruction_decode_if.sv
// Fetch/write-back/execute signal bundle for the RV32I decode stage.
// The decode stage binds to the slave modport; its environment binds to master.
interface instruction_decode_if;
  // fetch side
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;
  // write-back port
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  // execute side
  logic        ex_ready;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_rs1_data;
  logic [31:0] dec_rs2_data;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic [2:0]  dec_funct3;
  logic [3:0]  dec_alu_op;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_branch;
  logic        dec_jump;
  logic        dec_alu_src_imm;
  logic        dec_illegal;

  modport master (
    output instr_valid, instruction, instr_pc, wb_en, wb_rd, wb_data, ex_ready,
    input  instr_ready, dec_valid, dec_pc, dec_rs1_data, dec_rs2_data, dec_imm,
           dec_rd, dec_funct3, dec_alu_op, dec_reg_write, dec_mem_read,
           dec_mem_write, dec_branch, dec_jump, dec_alu_src_imm, dec_illegal
  );

  modport slave (
    input  instr_valid, instruction, instr_pc, wb_en, wb_rd, wb_data, ex_ready,
    output instr_ready, dec_valid, dec_pc, dec_rs1_data, dec_rs2_data, dec_imm,
           dec_rd, dec_funct3, dec_alu_op, dec_reg_write, dec_mem_read,
           dec_mem_write, dec_branch, dec_jump, dec_alu_src_imm, dec_illegal
  );
endinterface

// File: rtl/instruction_decode.sv
// RV32I decode stage: register file with write-back bypass, busy scoreboard
// for RAW interlock, immediate/control generation and an output hold register.
module instruction_decode (
  input  logic                 clk,
  input  logic                 rst,   // synchronous, active-low
  instruction_decode_if.slave  bus
);

  localparam int instr_size     = 32;
  localparam int reg_count      = 32;
  localparam int reg_addr_width = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [instr_size-1:0]     pc;
    logic [instr_size-1:0]     rs1_data;
    logic [instr_size-1:0]     rs2_data;
    logic [instr_size-1:0]     imm;
    logic [reg_addr_width-1:0] rd;
    logic [2:0]                funct3;
    logic [3:0]                alu_op;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      branch;
    logic                      jump;
    logic                      alu_src_imm;
    logic                      illegal;
  } dec_t;

  logic [instr_size-1:0]     inst;
  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [reg_addr_width-1:0] rs1, rs2, rd;
  logic [instr_size-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [instr_size-1:0]     rs1_val, rs2_val;
  logic                      uses_rs1, uses_rs2;
  logic                      hazard, ready, accept;
  dec_t                      dec_new;

  logic [instr_size-1:0]     rf_q [reg_count];
  logic [instr_size-1:0]     rf_d [reg_count];
  logic [reg_count-1:0]      busy_q, busy_d, busy_set, busy_clr;
  dec_t                      dec_q, dec_d;
  logic                      dec_valid_q, dec_valid_d;

  assign inst   = bus.instruction;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Operand read with same-cycle write-back bypass; x0 always reads zero.
  always_comb begin
    rs1_val = rf_q[rs1];
    rs2_val = rf_q[rs2];
    if (bus.wb_en && bus.wb_rd == rs1) rs1_val = bus.wb_data;
    if (bus.wb_en && bus.wb_rd == rs2) rs2_val = bus.wb_data;
    if (rs1 == '0) rs1_val = '0;
    if (rs2 == '0) rs2_val = '0;
  end

  // Opcode decode into the next output-register contents and source usage.
  // Every legal opcode ends in 2'b11, so the low-bit check is implied by the case.
  always_comb begin
    dec_new          = '0;
    uses_rs1         = 1'b0;
    uses_rs2         = 1'b0;
    dec_new.pc       = bus.instr_pc;
    dec_new.rd       = rd;
    dec_new.funct3   = funct3;
    dec_new.rs1_data = rs1_val;
    dec_new.rs2_data = rs2_val;
    case (opcode)
      OP_R: begin
        dec_new.alu_op    = {inst[30], funct3};
        dec_new.reg_write = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_I: begin
        // only the shift-right pair uses inst[30] as a modifier for immediates
        dec_new.alu_op      = {inst[30] & (funct3 == 3'b101), funct3};
        dec_new.imm         = imm_i;
        dec_new.reg_write   = 1'b1;
        dec_new.alu_src_imm = 1'b1;
        uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        dec_new.imm         = imm_i;
        dec_new.mem_read    = 1'b1;
        dec_new.reg_write   = 1'b1;
        dec_new.alu_src_imm = 1'b1;
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        dec_new.imm         = imm_s;
        dec_new.mem_write   = 1'b1;
        dec_new.alu_src_imm = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec_new.imm    = imm_b;
        dec_new.branch = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec_new.imm       = imm_j;
        dec_new.jump      = 1'b1;
        dec_new.reg_write = 1'b1;
      end
      OP_JALR: begin
        dec_new.imm         = imm_i;
        dec_new.jump        = 1'b1;
        dec_new.reg_write   = 1'b1;
        dec_new.alu_src_imm = 1'b1;
        uses_rs1 = 1'b1;
      end
      OP_LUI: begin
        dec_new.imm         = imm_u;
        dec_new.reg_write   = 1'b1;
        dec_new.alu_src_imm = 1'b1;
        dec_new.rs1_data    = '0;
      end
      OP_AUIPC: begin
        dec_new.imm         = imm_u;
        dec_new.reg_write   = 1'b1;
        dec_new.alu_src_imm = 1'b1;
      end
      default: begin
        dec_new.illegal = 1'b1;
      end
    endcase
  end

  // RAW interlock: a busy source stalls unless its write-back lands this cycle.
  always_comb begin
    hazard = 1'b0;
    if (uses_rs1 && rs1 != '0 && busy_q[rs1] && !(bus.wb_en && bus.wb_rd == rs1))
      hazard = 1'b1;
    if (uses_rs2 && rs2 != '0 && busy_q[rs2] && !(bus.wb_en && bus.wb_rd == rs2))
      hazard = 1'b1;
  end

  // No acceptance is advertised while reset is held.
  assign ready           = rst && (!dec_valid_q || bus.ex_ready) && !hazard;
  assign accept          = bus.instr_valid && ready;
  assign bus.instr_ready = ready;

  assign busy_set = (accept && dec_new.reg_write && rd != '0)
                    ? (reg_count'(1) << rd) : '0;
  assign busy_clr = bus.wb_en ? (reg_count'(1) << bus.wb_rd) : '0;

  // A set and clear on the same register resolve to set.
  generate
    for (genvar gi = 0; gi < reg_count; gi++) begin : g_busy
      assign busy_d[gi] = busy_set[gi] | (busy_q[gi] & ~busy_clr[gi]);
    end
  endgenerate

  // Register-file write port; x0 is never written.
  always_comb begin
    rf_d = rf_q;
    if (bus.wb_en && bus.wb_rd != '0) rf_d[bus.wb_rd] = bus.wb_data;
  end

  // Output register: load on accept, drop valid when execute takes it, else hold.
  always_comb begin
    dec_d       = dec_q;
    dec_valid_d = dec_valid_q;
    if (accept) begin
      dec_d       = dec_new;
      dec_valid_d = 1'b1;
    end else if (bus.ex_ready) begin
      dec_valid_d = 1'b0;
    end
  end

  // State registers; reset clears the held instruction, scoreboard and registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
      busy_q      <= '0;
      for (int i = 0; i < reg_count; i++) rf_q[i] <= '0;
    end else begin
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      busy_q      <= busy_d;
      rf_q        <= rf_d;
    end
  end

  assign bus.dec_valid       = dec_valid_q;
  assign bus.dec_pc          = dec_q.pc;
  assign bus.dec_rs1_data    = dec_q.rs1_data;
  assign bus.dec_rs2_data    = dec_q.rs2_data;
  assign bus.dec_imm         = dec_q.imm;
  assign bus.dec_rd          = dec_q.rd;
  assign bus.dec_funct3      = dec_q.funct3;
  assign bus.dec_alu_op      = dec_q.alu_op;
  assign bus.dec_reg_write   = dec_q.reg_write;
  assign bus.dec_mem_read    = dec_q.mem_read;
  assign bus.dec_mem_write   = dec_q.mem_write;
  assign bus.dec_branch      = dec_q.branch;
  assign bus.dec_jump        = dec_q.jump;
  assign bus.dec_alu_src_imm = dec_q.alu_src_imm;
  assign bus.dec_illegal     = dec_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Testbench for instruction_decode: directed scenarios then random traffic,
// checked each cycle against a behavioural model of the decode stage.
module tb_instruction_decode;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        rw, mr, mw, br, jp, asi, ill;
  } exp_t;

  exp_t        exp_out;
  logic        exp_valid;
  logic [31:0] m_rf [32];
  logic        m_busy [32];
  logic [31:0] pc_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] m = 32'hFFFF_FFFF << bits;
    return v[bits-1] ? (v | m) : v;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
    return m_rf[r];
  endfunction

  // bit1: reads rs1, bit0: reads rs2
  function automatic logic [1:0] src_use(input logic [31:0] inst);
    case (inst[6:0])
      7'h33, 7'h23, 7'h63: return 2'b11;
      7'h13, 7'h03, 7'h67: return 2'b10;
      default:             return 2'b00;
    endcase
  endfunction

  function automatic logic model_hazard(input logic [31:0] inst);
    logic [1:0] u  = src_use(inst);
    logic [4:0] r1 = inst[19:15];
    logic [4:0] r2 = inst[24:20];
    logic       h  = 1'b0;
    if (u[1] && r1 != 0 && m_busy[r1] && !(bus.wb_en && bus.wb_rd == r1)) h = 1'b1;
    if (u[0] && r2 != 0 && m_busy[r2] && !(bus.wb_en && bus.wb_rd == r2)) h = 1'b1;
    return h;
  endfunction

  function automatic exp_t model_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t       e  = '0;
    logic [2:0] f3 = inst[14:12];
    e.pc  = pc;
    e.rd  = inst[11:7];
    e.f3  = f3;
    e.rs1 = model_read(inst[19:15]);
    e.rs2 = model_read(inst[24:20]);
    case (inst[6:0])
      7'h33: begin e.alu = {inst[30], f3}; e.rw = 1; end
      7'h13: begin
        e.imm = sext({20'b0, inst[31:20]}, 12);
        e.alu = (f3 == 3'b101) ? {inst[30], f3} : {1'b0, f3};
        e.rw = 1; e.asi = 1;
      end
      7'h03: begin e.imm = sext({20'b0, inst[31:20]}, 12); e.mr = 1; e.rw = 1; e.asi = 1; end
      7'h23: begin e.imm = sext({20'b0, inst[31:25], inst[11:7]}, 12); e.mw = 1; e.asi = 1; end
      7'h63: begin
        e.imm = sext({19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
        e.br = 1;
      end
      7'h6F: begin
        e.imm = sext({11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
        e.jp = 1; e.rw = 1;
      end
      7'h67: begin e.imm = sext({20'b0, inst[31:20]}, 12); e.jp = 1; e.rw = 1; e.asi = 1; end
      7'h37: begin e.imm = {inst[31:12], 12'h000}; e.rw = 1; e.asi = 1; e.rs1 = 32'd0; end
      7'h17: begin e.imm = {inst[31:12], 12'h000}; e.rw = 1; e.asi = 1; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic check_outputs();
    chk("dec_valid",   32'(bus.dec_valid),       32'(exp_valid));
    chk("dec_pc",      bus.dec_pc,               exp_out.pc);
    chk("dec_rs1",     bus.dec_rs1_data,         exp_out.rs1);
    chk("dec_rs2",     bus.dec_rs2_data,         exp_out.rs2);
    chk("dec_imm",     bus.dec_imm,              exp_out.imm);
    chk("dec_rd",      32'(bus.dec_rd),          32'(exp_out.rd));
    chk("dec_funct3",  32'(bus.dec_funct3),      32'(exp_out.f3));
    chk("dec_alu_op",  32'(bus.dec_alu_op),      32'(exp_out.alu));
    chk("dec_rw",      32'(bus.dec_reg_write),   32'(exp_out.rw));
    chk("dec_mr",      32'(bus.dec_mem_read),    32'(exp_out.mr));
    chk("dec_mw",      32'(bus.dec_mem_write),   32'(exp_out.mw));
    chk("dec_br",      32'(bus.dec_branch),      32'(exp_out.br));
    chk("dec_jp",      32'(bus.dec_jump),        32'(exp_out.jp));
    chk("dec_asi",     32'(bus.dec_alu_src_imm), 32'(exp_out.asi));
    chk("dec_illegal", 32'(bus.dec_illegal),     32'(exp_out.ill));
  endtask

  // One clock: check ready before the edge, advance the model at the edge,
  // check the output register after it.
  task automatic step();
    logic exp_ready;
    logic acc;
    exp_t nxt;
    #1;
    exp_ready = rst && (!exp_valid || bus.ex_ready) && !model_hazard(bus.instruction);
    if (rst) chk("instr_ready", 32'(bus.instr_ready), 32'(exp_ready));
    @(posedge clk);
    if (!rst) begin
      exp_out   = '0;
      exp_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
        m_rf[i]   = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      acc = bus.instr_valid && exp_ready;
      nxt = model_decode(bus.instruction, bus.instr_pc);
      if (acc) begin
        exp_out   = nxt;
        exp_valid = 1'b1;
      end else if (bus.ex_ready) begin
        exp_valid = 1'b0;
      end
      if (bus.wb_en) m_busy[bus.wb_rd] = 1'b0;
      if (acc && nxt.rw && nxt.rd != 0) m_busy[nxt.rd] = 1'b1;
      if (bus.wb_en && bus.wb_rd != 0) m_rf[bus.wb_rd] = bus.wb_data;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic exr,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
    bus.instr_valid = v;
    bus.instruction = inst;
    bus.instr_pc    = pc_cnt;
    bus.ex_ready    = exr;
    bus.wb_en       = we;
    bus.wb_rd       = wrd;
    bus.wb_data     = wdat;
    pc_cnt          = pc_cnt + 32'd4;
  endtask

  function automatic logic [6:0] pick_opcode(input int idx);
    case (idx)
      0: return 7'h33;
      1: return 7'h13;
      2: return 7'h03;
      3: return 7'h23;
      4: return 7'h63;
      5: return 7'h6F;
      6: return 7'h67;
      7: return 7'h37;
      8: return 7'h17;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    logic [31:0] word;
    logic [4:0]  busy_list [$];
    logic [4:0]  wrd;
    exp_out   = '0;
    exp_valid = 1'b0;
    pc_cnt    = 32'h0000_1000;
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = 32'd0;
      m_busy[i] = 1'b0;
    end

    // reset
    rst = 1'b0;
    drive(1'b0, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    step();
    step();
    chk("reset_valid", 32'(bus.dec_valid), 32'd0);

    // first cycle out of reset: ready must be up
    rst = 1'b1;
    drive(1'b0, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 32'd0);
    step();

    // ADDI x1,x0,5
    drive(1'b1, 32'h0050_0093, 1'b1, 1'b0, 5'd0, 32'd0);
    step();
    chk("addi_valid", 32'(bus.dec_valid), 32'd1);
    chk("addi_rd",    32'(bus.dec_rd),    32'd1);
    chk("addi_imm",   bus.dec_imm,        32'd5);
    chk("addi_alu",   32'(bus.dec_alu_op), 32'd0);
    chk("addi_rw",    32'(bus.dec_reg_write), 32'd1);
    chk("addi_asi",   32'(bus.dec_alu_src_imm), 32'd1);

    // ADD x2,x1,x1 stalls on x1 until its write-back
    drive(1'b1, 32'h0010_8133, 1'b1, 1'b0, 5'd0, 32'd0);
    #1 chk("raw_stall_ready", 32'(bus.instr_ready), 32'd0);
    step();
    step();
    drive(1'b1, 32'h0010_8133, 1'b1, 1'b1, 5'd1, 32'd5);
    #1 chk("raw_release_ready", 32'(bus.instr_ready), 32'd1);
    step();
    chk("raw_rs1", bus.dec_rs1_data, 32'd5);
    chk("raw_rs2", bus.dec_rs2_data, 32'd5);

    // BEQ x0,x0,-4
    drive(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0, 5'd0, 32'd0);
    step();
    chk("beq_imm", bus.dec_imm, 32'hFFFF_FFFC);
    chk("beq_br",  32'(bus.dec_branch), 32'd1);
    chk("beq_rw",  32'(bus.dec_reg_write), 32'd0);

    // SW x2,8(x1) with x2's write-back arriving in the same cycle
    drive(1'b1, 32'h0020_A423, 1'b1, 1'b1, 5'd2, 32'h0000_0010);
    step();
    chk("sw_imm", bus.dec_imm, 32'd8);
    chk("sw_mw",  32'(bus.dec_mem_write), 32'd1);

    // backpressure: ex_ready low for three cycles
    drive(1'b1, 32'h0070_0193, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    step();
    step();
    chk("bp_hold_imm", bus.dec_imm, 32'd8);
    bus.ex_ready = 1'b1;
    step();
    chk("bp_next_imm", bus.dec_imm, 32'd7);
    chk("bp_next_rd",  32'(bus.dec_rd), 32'd3);
    drive(1'b0, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 32'd0);
    step();

    // x0 stays zero, including the same-cycle bypass path
    drive(1'b1, 32'h0000_0233, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step();
    chk("x0_bypass_rs1", bus.dec_rs1_data, 32'd0);
    drive(1'b1, 32'h0000_0233, 1'b1, 1'b0, 5'd0, 32'd0);
    step();
    chk("x0_read_rs2", bus.dec_rs2_data, 32'd0);

    // illegal word, then a reader of x31 must not stall
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0, 32'd0);
    step();
    chk("ill_flag", 32'(bus.dec_illegal), 32'd1);
    chk("ill_ctrl", 32'({bus.dec_reg_write, bus.dec_mem_read, bus.dec_mem_write,
                         bus.dec_branch, bus.dec_jump}), 32'd0);
    drive(1'b1, 32'h01FF_82B3, 1'b1, 1'b0, 5'd0, 32'd0);
    step();
    chk("ill_no_busy_rd", 32'(bus.dec_rd), 32'd5);

    // reset while holding
    drive(1'b1, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_hold_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_hold_pc",    bus.dec_pc, 32'd0);
    rst = 1'b1;
    drive(1'b0, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 32'd0);
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      word = $urandom();
      busy_list.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(5'(r));
      wrd = 5'($urandom_range(0, 31));
      if (busy_list.size() > 0 && $urandom_range(0, 1) == 1)
        wrd = busy_list[$urandom_range(0, busy_list.size() - 1)];
      drive($urandom_range(0, 3) != 0,
            {word[31:7], pick_opcode($urandom_range(0, 9))},
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0,
            wrd,
            $urandom());
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

RV32I decode stage sitting directly downstream of `instruction_fetch`. Accepts one fetched instruction per cycle under a valid/ready handshake. Reads operands from an internal 32×32 register file with write-back bypass and generates the sign-extended immediate and control fields. Interlocks on read-after-write hazards via a per-register busy scoreboard, and holds the decoded instruction in an output register until execute accepts it.

## Interface
- `instr_size`, 32, instruction/data width (fixed by RV32I).
- `reg_count`, 32, architectural registers; x0 is hardwired to zero.
- `reg_addr_width`, 5, register index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `instr_valid` in 1: fetch presents an instruction.
- `instruction` in 32: instruction word from fetch.
- `instr_pc` in 32: PC of `instruction`.
- `instr_ready` out 1: decode accepts this cycle.
- `wb_en` in 1, `wb_rd` in 5, `wb_data` in 32: write-back port.
- `ex_ready` in 1: execute accepts the decoded instruction.
- `dec_valid` out 1: output register holds a valid instruction.
- `dec_pc` out 32: PC of the held instruction.
- `dec_rs1_data` out 32, `dec_rs2_data` out 32: operand values.
- `dec_imm` out 32: sign-extended immediate.
- `dec_rd` out 5: destination register.
- `dec_funct3` out 3: raw funct3, used by branch, load and store.
- `dec_alu_op` out 4: `{alt, funct3}`.
- `dec_reg_write`, `dec_mem_read`, `dec_mem_write`, `dec_branch`, `dec_jump`, `dec_alu_src_imm`, `dec_illegal` out 1 each.

## Operation
- **Accept condition:** accept when `instr_valid && instr_ready`.
- **Ready:**
  - `instr_ready = (!dec_valid || ex_ready) && !hazard`.
  - `hazard` is true if a used rs1 or rs2 (nonzero) is busy and is not being cleared by `wb_en`/`wb_rd` this cycle.
- **Source usage:**
  - rs1 is used by R, I, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by R, STORE and BRANCH.
- **Output register on accept:** loads all `dec_*` fields and sets `dec_valid=1`.
- **Output register otherwise:**
  - If `ex_ready`, clear `dec_valid`.
  - Else hold every output unchanged.
- **Register file:**
  - 32×32, written on `wb_en` when `wb_rd!=0`; writes to x0 are ignored.
  - Reads are bypassed: if `wb_en && wb_rd==rs && rs!=0`, the operand is `wb_data`.
- **Scoreboard:**
  - A busy bit per register.
  - Set for rd (rd≠0) when an instruction with `dec_reg_write` is accepted.
  - Cleared on `wb_en` for `wb_rd`.
  - If set and clear hit the same register in the same cycle, set wins.
- **Immediates:**
  - I: `inst[31:20]`.
  - S: `{inst[31:25],inst[11:7]}`.
  - B: `{inst[31],inst[7],inst[30:25],inst[11:8],0}`.
  - U: `{inst[31:12],12'b0}`.
  - J: `{inst[31],inst[19:12],inst[20],inst[30:21],0}`.
  - I, S, B and J are sign-extended to 32 bits.
- **Opcode decode:**
  - R `0110011`: `alu_op={inst[30],funct3}`, `reg_write`.
  - I `0010011`: `alu_op={inst[30]&(funct3==101),funct3}`, `reg_write`, `alu_src_imm`.
  - LOAD `0000011`: ADD, `mem_read`, `reg_write`, `alu_src_imm`.
  - STORE `0100011`: ADD, `mem_write`, `alu_src_imm`.
  - BRANCH `1100011`: `branch`, `alu_op=0000`.
  - JAL `1101111`: `jump`, `reg_write`.
  - JALR `1100111`: `jump`, `reg_write`, `alu_src_imm`.
  - LUI `0110111`: ADD, `reg_write`, `alu_src_imm`, `dec_rs1_data` forced to 0.
  - AUIPC `0010111`: ADD, `reg_write`, `alu_src_imm`.
- **Illegal instructions:**
  - Any other opcode, or `inst[1:0]!=11`, is illegal.
  - It passes through with `dec_illegal=1` and all write/mem/branch/jump controls 0.
  - It does not set the scoreboard.

## Timing
- Accept to `dec_valid` is one cycle.
- Throughput is one instruction per cycle with no hazard and `ex_ready=1`.
- A RAW hazard stalls until the clearing `wb_en` cycle. The instruction is accepted in that same cycle with the bypassed operand.
- `instr_ready` is combinational on `ex_ready`, `wb_en`, `wb_rd` and `instruction`.
- **Reset (`rst=0` at a clock edge):**
  - All `dec_*` outputs are 0 and `dec_valid=0`.
  - The register file and scoreboard are zeroed.
  - `instr_ready` becomes 1 the cycle after reset deasserts.
- **Reset mid-stall or mid-hold:** the held instruction is dropped; nothing is replayed.

## Test plan
- **Basic decode:** reset, then `0x00500093` (ADDI x1,x0,5) → next cycle: `dec_valid=1`, `dec_rd=1`, `dec_imm=5`, `alu_op=0000`, `reg_write=1`, `alu_src_imm=1`.
- **RAW stall and bypass:** follow with `0x00108133` (ADD x2,x1,x1) → `instr_ready=0` until `wb_en=1,wb_rd=1,wb_data=5`. Accepted that cycle with `dec_rs1_data=dec_rs2_data=5`.
- **Negative immediates:** `0xFE000EE3` (BEQ x0,x0,-4) → `dec_imm=0xFFFFFFFC`, `branch=1`, `reg_write=0`. `0x0020A423` (SW x2,8(x1)) → `dec_imm=8`, `mem_write=1`.
- **Backpressure:** hold `ex_ready=0` for 3 cycles with `instr_valid=1` → outputs stable, `instr_ready=0`. Release → the next instruction appears one cycle later, with no loss or duplication.
- **x0 and illegal:** `wb_en=1,wb_rd=0,wb_data=0xDEADBEEF` then read x0 → 0. Send `0xFFFFFFFF` → `dec_illegal=1`, all controls 0, no scoreboard bit set.
- **Reset during hold:** assert `rst=0` during a hold → `dec_valid=0` and all outputs 0 on the next edge.
